// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM types and constants for the GPU/CPU VRAM access path.
// The arbiter's FSM state and response-owner encodings are defined here.
package vram_arbiter_pkg;

  localparam int unsigned VramSize      = 2304;
  localparam int unsigned VramAddrWidth = 12;
  localparam int unsigned DataWidth     = 8;

  typedef logic [VramAddrWidth-1:0] vram_address_t;
  typedef logic [DataWidth-1:0]     data_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } vram_arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GPU  = 2'd1,
    OWN_CPU  = 2'd2
  } vram_owner_t;

  localparam vram_address_t VramLastAddr = vram_address_t'(VramSize - 1);

  function automatic logic addr_in_range(input vram_address_t addr);
    return addr <= VramLastAddr;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/response buses of both VRAM clients plus the VRAM macro port.
// slave = arbiter side, master = requesters and memory side.
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  logic          gpu_req_valid;
  vram_address_t gpu_req_addr;
  logic          gpu_req_ready;
  logic          gpu_rsp_valid;
  data_t         gpu_rsp_data;

  logic          cpu_req_valid;
  logic          cpu_req_we;
  vram_address_t cpu_req_addr;
  data_t         cpu_req_wdata;
  logic          cpu_req_ready;
  logic          cpu_rsp_valid;
  data_t         cpu_rsp_data;

  vram_address_t mem_addr;
  logic          mem_we;
  data_t         mem_wdata;
  data_t         mem_rdata;

  modport slave (
    input  gpu_req_valid, gpu_req_addr,
    output gpu_req_ready, gpu_rsp_valid, gpu_rsp_data,
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output gpu_req_valid, gpu_req_addr,
    input  gpu_req_ready, gpu_rsp_valid, gpu_rsp_data,
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: post-reset clear sequence, then GPU-priority
// arbitration with a bounded-wait override that guarantees CPU progress.
//
// state | meaning
// CLEAR | zeroing VRAM 0x000..0x8FF, one write per cycle, no grants
// RUN   | per-cycle arbitration between GPU and CPU
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ClearOnReset = 1,
  parameter int unsigned CpuMaxWait   = 4
) (
  input  logic           clk_gpu,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus,
  output logic           busy_clearing
);

  localparam logic [0:0] ST_CLEAR = CLEAR;
  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_RESET = (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [3:0] MaxWait  = 4'(CpuMaxWait);

  logic [0:0]    state_q, state_d;
  vram_address_t clr_cnt_q, clr_cnt_d;
  logic [3:0]    wait_q, wait_d;
  vram_owner_t   owner_q, owner_d;
  logic          oor_q, oor_d;
  data_t         gpu_data_q, gpu_data_d;
  data_t         cpu_data_q, cpu_data_d;

  logic          in_run;
  logic          clearing;
  logic          cpu_force;
  logic          gpu_grant;
  logic          cpu_grant;
  data_t         rsp_data;

  // rst_n gates the combinational outputs so an asserted reset shows the
  // idle port and no grants immediately, independent of the reset state.
  assign in_run    = rst_n && (state_q == ST_RUN);
  assign clearing  = rst_n && (state_q == ST_CLEAR);

  assign cpu_force = in_run && bus.cpu_req_valid && (wait_q == MaxWait);
  assign gpu_grant = in_run && bus.gpu_req_valid && !cpu_force;
  assign cpu_grant = in_run && bus.cpu_req_valid && !gpu_grant;

  assign bus.gpu_req_ready = gpu_grant;
  assign bus.cpu_req_ready = cpu_grant;
  assign busy_clearing     = (state_q == ST_CLEAR);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (clearing) begin
      bus.mem_addr = clr_cnt_q;
      bus.mem_we   = 1'b1;
    end else if (gpu_grant) begin
      bus.mem_addr  = bus.gpu_req_addr;
      bus.mem_wdata = bus.cpu_req_wdata;
    end else if (cpu_grant) begin
      bus.mem_addr  = bus.cpu_req_addr;
      bus.mem_we    = bus.cpu_req_we && addr_in_range(bus.cpu_req_addr);
      bus.mem_wdata = bus.cpu_req_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == VramLastAddr) begin
        clr_cnt_d = '0;
        state_d   = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!in_run || !bus.cpu_req_valid || cpu_grant) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    oor_d   = 1'b0;
    if (gpu_grant) begin
      owner_d = OWN_GPU;
      oor_d   = !addr_in_range(bus.gpu_req_addr);
    end else if (cpu_grant && !bus.cpu_req_we) begin
      owner_d = OWN_CPU;
      oor_d   = !addr_in_range(bus.cpu_req_addr);
    end
  end

  // Read data is taken straight from the macro in the response cycle and
  // then held in the per-client register until the next response.
  assign rsp_data          = oor_q ? '0 : bus.mem_rdata;
  assign bus.gpu_rsp_valid = (owner_q == OWN_GPU);
  assign bus.cpu_rsp_valid = (owner_q == OWN_CPU);
  assign bus.gpu_rsp_data  = bus.gpu_rsp_valid ? rsp_data : gpu_data_q;
  assign bus.cpu_rsp_data  = bus.cpu_rsp_valid ? rsp_data : cpu_data_q;
  assign gpu_data_d        = bus.gpu_rsp_data;
  assign cpu_data_d        = bus.cpu_rsp_data;

  always_ff @(posedge clk_gpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      clr_cnt_q  <= '0;
      wait_q     <= '0;
      owner_q    <= OWN_NONE;
      oor_q      <= 1'b0;
      gpu_data_q <= '0;
      cpu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      oor_q      <= oor_d;
      gpu_data_q <= gpu_data_d;
      cpu_data_q <= cpu_data_d;
    end
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access controller shared between the GPU pixel-fetch pipeline and the CPU bus bridge, both in the GPU clock domain. After reset it sequences a full VRAM clear, then arbitrates per cycle. The GPU has fixed priority, and a bounded-wait rule guarantees CPU forward progress. It sits between the two requesters and the 0x900-byte synchronous VRAM macro, which has 1-cycle read latency.

## Interface

- `ClearOnReset`, 1: when 1, zero all of VRAM after reset; when 0, go directly to RUN.
- `CpuMaxWait`, 4: number of consecutive cycles a pending CPU request may be denied before it is forced through (range 1–15).
- `clk_gpu` in 1: GPU clock. The block uses this single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `gpu_req_valid` in 1: GPU read request.
- `gpu_req_addr` in 12: GPU read address (`vram_address_t`).
- `gpu_req_ready` out 1: GPU request granted this cycle.
- `gpu_rsp_valid` out 1: GPU read data valid.
- `gpu_rsp_data` out 8: GPU read data (`data_t`).
- `cpu_req_valid` in 1: CPU request.
- `cpu_req_we` in 1: 1 = write, 0 = read.
- `cpu_req_addr` in 12: CPU address.
- `cpu_req_wdata` in 8: CPU write data.
- `cpu_req_ready` out 1: CPU request granted this cycle.
- `cpu_rsp_valid` out 1: CPU read data valid (reads only).
- `cpu_rsp_data` out 8: CPU read data.
- `busy_clearing` out 1: high while in the CLEAR state.
- `mem_addr` out 12: VRAM address.
- `mem_we` out 1: VRAM write enable.
- `mem_wdata` out 8: VRAM write data.
- `mem_rdata` in 8: VRAM read data, valid the cycle after the address is presented.

## Operation

**States**
- CLEAR: entered on reset when `ClearOnReset`=1.
- RUN: entered on reset when `ClearOnReset`=0, and from CLEAR when the clear completes.

**CLEAR**
- Counter runs 0x000 to 0x8FF. Each cycle: `mem_we`=1, `mem_wdata`=0x00, `mem_addr`=counter.
- After writing 0x8FF, go to RUN. The clear takes exactly 2304 cycles.
- Both ready outputs are 0 and `busy_clearing`=1 throughout.

**RUN grant rule (per cycle)**
- If the CPU wait count equals `CpuMaxWait` and `cpu_req_valid`=1, grant the CPU.
- Otherwise, if `gpu_req_valid`=1, grant the GPU.
- Otherwise, if `cpu_req_valid`=1, grant the CPU.
- Otherwise, no grant.
- At most one ready output is high in any cycle.

**Wait counter**
- Increments in each cycle where `cpu_req_valid`=1 and the CPU is not granted.
- Clears when the CPU is granted, or when `cpu_req_valid`=0.
- Saturates at `CpuMaxWait`.

**Memory port on a grant**
- `mem_addr` = the granted request's address.
- `mem_we` = `cpu_req_we` for a CPU grant; 0 for a GPU grant.
- `mem_wdata` = `cpu_req_wdata`.

**Idle memory port**
- `mem_we`=0 and `mem_addr`=0.
- `mem_wdata`=0.

**Out-of-range addresses (>= `VramSize`)**
- The request is still granted.
- A write is dropped: `mem_we` stays 0.
- A read returns 0x00 and does not depend on `mem_rdata`.

**Requester rules**
- A requester must hold valid and its address/data stable until ready is seen.
- Back-to-back requests are allowed every cycle.

## Timing

**Reset values**
- All ready and rsp_valid outputs: 0.
- All rsp_data outputs: 0x00.
- `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `busy_clearing` = `ClearOnReset`.
- Wait counter and clear counter: 0.

**Grant and memory port**
- The ready outputs and the `mem_*` outputs are combinational from the current-cycle valids, the FSM state and the wait count.

**Read response**
- A read granted in cycle N produces rsp_valid=1 in cycle N+1 for exactly one cycle.
- rsp_data carries `mem_rdata`, or 0x00 if the address was out of range.
- The owner and out-of-range flag for N+1 are registered.
- rsp_data is held between responses.
- CPU writes produce no response.

**Starvation bound**
- A pending CPU request is granted no later than `CpuMaxWait` cycles after valid rises.

**Reset mid-operation**
- Asynchronous assertion of `rst_n` forces the reset values immediately.
- Any in-flight read response is discarded.
- A clear interrupted by reset restarts from 0x000.

**Requests during CLEAR**
- Valids asserted during CLEAR are held off, not dropped.
- Such a request may be granted in the first RUN cycle.

## Structure

- **Shared package additions**
  - `vram_arb_state_t` enum {CLEAR, RUN}.
  - `vram_owner_t` enum {OWN_NONE, OWN_GPU, OWN_CPU}.
- **Existing package items reused**
  - `VramSize`, `VramAddrWidth`, `vram_address_t`, `data_t`.
- **Sub-modules:** none. The clear counter, the wait counter and the response register stay inline in one module.

## Test plan

- **Reset clear:** preload VRAM with 0xA5, release reset.
  - `busy_clearing` stays high for 2304 cycles.
  - Then read-back of 0x000, 0x47F and 0x8FF all return 0x00.
- **Priority:** GPU and CPU both request, GPU reads 0x010 and CPU writes 0x020.
  - GPU is granted.
  - `gpu_rsp_valid` rises next cycle with the stored data.
  - CPU is granted the cycle after GPU valid drops.
- **Starvation:** GPU requests every cycle, CPU holds a write of 0x3C to 0x100.
  - With `CpuMaxWait`=4, CPU ready rises on the 5th cycle of its request.
  - That cycle `gpu_req_ready`=0.
  - A later read of 0x100 returns 0x3C.
- **Out of range:** CPU writes 0x77 to 0x900, then reads 0xFFF.
  - The write shows `mem_we`=0.
  - The read returns 0x00 with `cpu_rsp_valid`=1.
- **Back-to-back:** GPU reads 0x000–0x00F on consecutive cycles.
  - 16 consecutive `gpu_rsp_valid` pulses, in order, with the correct data.
- **Reset mid-clear:** assert `rst_n`=0 at clear cycle 1000, release.
  - All outputs show reset values while reset is asserted.
  - The clear restarts at 0x000 and lasts the full 2304 cycles.
